// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory req/ack port bundle for load_store_unit
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I multi-cycle load/store unit; optional request timeout via LSU_TIMEOUT_EN
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic                      err,
    load_store_unit_if.master         mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        r_store;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_err;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        accept;
    logic        bad_req;
    logic        ack_hit;
    logic        timeout_hit;
    logic [31:0] wdata_c;
    logic [3:0]  wstrb_c;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_c;

    assign accept  = (state == IDLE) && start;
    assign ack_hit = (state == REQ) && mem.mem_ack;

    // Classify the incoming request: illegal encodings and misaligned halves/words never reach memory
    always_comb begin
        bad_req = 1'b0;
        if ((funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]))
            bad_req = 1'b1;
        if ((funct3[1:0] == 2'b01) && addr[0])
            bad_req = 1'b1;
        if ((funct3 == 3'b010) && (addr[1:0] != 2'b00))
            bad_req = 1'b1;
    end

    // Replicate store data across lanes and build the byte strobes from the low address bits
    always_comb begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_c = {4{store_data[7:0]}};
                wstrb_c = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_c = {2{store_data[15:0]}};
                wstrb_c = 4'b0011 << addr[1:0];
            end
            default: begin
                wdata_c = store_data;
                wstrb_c = 4'b1111;
            end
        endcase
        if (!is_store)
            wstrb_c = 4'b0000;
    end

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        byte_v = mem.mem_rdata[7:0];
        case (r_off)
            2'b00:   byte_v = mem.mem_rdata[7:0];
            2'b01:   byte_v = mem.mem_rdata[15:8];
            2'b10:   byte_v = mem.mem_rdata[23:16];
            default: byte_v = mem.mem_rdata[31:24];
        endcase
        half_v = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_f3)
            3'b000:  ext_c = {{24{byte_v[7]}}, byte_v};
            3'b001:  ext_c = {{16{half_v[15]}}, half_v};
            3'b100:  ext_c = {24'd0, byte_v};
            3'b101:  ext_c = {16'd0, half_v};
            default: ext_c = mem.mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_cnt;

    assign timeout_hit = (state == REQ) && !mem.mem_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting in REQ; cleared whenever the request is not outstanding
    always_ff @(posedge clk) begin
        if (rst || (state != REQ))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: errors skip memory, REQ waits for ack (or expiry), RESP lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = bad_req ? RESP : REQ;
            REQ:  if (ack_hit || timeout_hit) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, memory-side output registers and load result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store   <= 1'b0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_err     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            load_data <= '0;
        end else begin
            if (accept) begin
                r_store <= is_store;
                r_f3    <= funct3;
                r_off   <= addr[1:0];
                r_err   <= bad_req;
                if (!bad_req) begin
                    addr_q  <= {addr[31:2], 2'b00};
                    wdata_q <= wdata_c;
                    wstrb_q <= wstrb_c;
                end
            end
            if (ack_hit && !r_store)
                load_data <= ext_c;
            if (timeout_hit)
                r_err <= 1'b1;
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == RESP);
    assign err           = (state == RESP) && r_err;
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = (state == REQ) && r_store;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table and scoreboard bench for load_store_unit
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err;

    load_store_unit_if mif ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        logic        e_err;
        logic [31:0] e_load;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] load;
        int          lat;
        int          nreq;
    } exp_t;

    localparam int NV = 17;
    vec_t        vecs [NV];
    exp_t        sb [$];
    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] last_load = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t x;
        int   cyc;
        int   reqcnt;
        bit   seen;
        x.err  = v.e_err;
        x.lat  = v.e_err ? 1 : v.dly + 2;
        x.nreq = v.e_err ? 0 : v.dly + 1;
        x.load = (v.st || v.e_err) ? last_load : v.e_load;
        sb.push_back(x);
        if (!v.st && !v.e_err)
            last_load = v.e_load;
        @(negedge clk);
        start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; store_data = v.sd;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; reqcnt = 0; seen = 0;
        while (!seen && cyc < 60) begin
            if (mif.mem_req) begin
                if (reqcnt == 0) begin
                    chk("mem_addr", mif.mem_addr, v.e_addr);
                    chk("mem_we", 32'(mif.mem_we), 32'(v.st));
                    chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(v.e_wstrb));
                    if (v.st)
                        chk("mem_wdata", mif.mem_wdata, v.e_wdata);
                end
                mif.mem_ack   = (reqcnt == v.dly);
                mif.mem_rdata = v.rd;
                reqcnt++;
            end else begin
                mif.mem_ack = 1'b0;
            end
            if (done) begin
                x = sb.pop_front();
                chk("latency", 32'(cyc), 32'(x.lat));
                chk("req_cycles", 32'(reqcnt), 32'(x.nreq));
                chk("err", 32'(err), 32'(x.err));
                chk("load_data", load_data, x.load);
                chk("busy_at_done", 32'(busy), 32'd1);
                seen = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mif.mem_ack = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int  reqs;
        int  cyc;
        bit  got;
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h100, 32'h0,        4'b0000};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 1'b0, 32'hFFFFFF80, 32'h100, 32'h0,        4'b0000};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 1'b0, 32'h00000080, 32'h100, 32'h0,        4'b0000};
        vecs[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80112233, 0, 1'b0, 32'h00008011, 32'h100, 32'h0,        4'b0000};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 2, 1'b0, 32'hFFFF8011, 32'h100, 32'h0,        4'b0000};
        vecs[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h80112233, 0, 1'b0, 32'h00000022, 32'h100, 32'h0,        4'b0000};
        vecs[6]  = '{1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        1, 1'b0, 32'h0,        32'h204, 32'hABCDABCD, 4'b1100};
        vecs[7]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 1'b0, 32'h0,        32'h300, 32'hA5A5A5A5, 4'b0010};
        vecs[8]  = '{1'b1, 3'b010, 32'h40C, 32'h89ABCDEF, 32'h0,        3, 1'b0, 32'h0,        32'h40C, 32'h89ABCDEF, 4'b1111};
        vecs[9]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};
        vecs[10] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};
        vecs[11] = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};
        vecs[12] = '{1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};
        vecs[13] = '{1'b0, 3'b110, 32'h0,   32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};
        vecs[14] = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h0000FFFE, 0, 1'b0, 32'h0000FFFE, 32'h100, 32'h0,        4'b0000};
        vecs[15] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h0000FFFE, 1, 1'b0, 32'hFFFFFFFE, 32'h100, 32'h0,        4'b0000};
        vecs[16] = '{1'b1, 3'b010, 32'h402, 32'h11111111, 32'h0,        0, 1'b1, 32'h0,        32'h0,   32'h0,        4'b0000};

        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ctrl", {26'd0, busy, done, err, mif.mem_req, mif.mem_we, 1'b0}, 32'd0);
        chk("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i]);

        // error request, then a valid start held through RESP must be ignored
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h101;
        @(posedge clk); #1;
        is_store = 1'b1; addr = 32'h300; store_data = 32'h55AA55AA;
        chk("busy_err_done", {29'd0, done, err, mif.mem_req}, 32'b110);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ignored", {30'd0, busy, mif.mem_req}, 32'd0);
        got = 0;
        for (int i = 0; i < 3; i++) begin
            if (done || mif.mem_req) got = 1;
            @(posedge clk); #1;
        end
        chk("busy_no_extra", 32'(got), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // ack withheld: mem_req for TO cycles then an error completion
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0; reqs = 0; cyc = 1;
        while (!done && cyc < 40) begin
            if (mif.mem_req) reqs++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("to_done", 32'(done), 32'd1);
        chk("to_req_cycles", 32'(reqs), 32'(TO));
        chk("to_err", 32'(err), 32'd1);
        chk("to_latency", 32'(cyc), 32'(TO + 1));
        chk("to_load_kept", load_data, last_load);
        @(posedge clk); #1;
`else
        // without the timeout, REQ waits as long as the memory does
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0; got = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || !mif.mem_req) got = 1;
            @(posedge clk); #1;
        end
        chk("wait_req_held", 32'(got), 32'd0);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        chk("wait_done", {30'd0, done, err}, 32'b10);
        chk("wait_load", load_data, 32'h12345678);
        last_load = 32'h12345678;
        @(posedge clk); #1;
`endif

        // reset while a request is outstanding; the ack in the reset cycle is dropped
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(mif.mem_req), 32'd1);
        rst = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0; mif.mem_ack = 1'b0;
        chk("midrst_ctrl", {29'd0, mif.mem_req, busy, done}, 32'd0);
        chk("midrst_load", load_data, 32'd0);
        got = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) got = 1;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 32'(got), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
